// File: rtl/nbin_zero_skip_window.sv
// Zero-skipping window between NBin and NFU-1: holds D input vectors and, per lane,
// promotes the oldest pending non-zero value so NFU-1 never spends a lane on a zero neuron.
module nbin_zero_skip_window #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int D         = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [BIT_WIDTH*Tn-1:0]  i_inputs,
    input  logic                     i_last,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [BIT_WIDTH*Tn-1:0]  o_outputs,
    output logic [SEL_WIDTH*Tn-1:0]  o_sel_lines,
    output logic [Tn-1:0]            o_lane_valid,
    output logic                     o_last
);
    localparam int CW = $clog2(D + 1);
    localparam int VW = BIT_WIDTH * Tn;

    logic [VW-1:0]           data_q [D];
    logic [VW-1:0]           data_d [D];
    logic [Tn-1:0]           pend_q [D];
    logic [Tn-1:0]           pend_d [D];
    logic [D-1:0]            last_q, last_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    valid_q, valid_d;
    logic [VW-1:0]           outputs_q, outputs_d;
    logic [SEL_WIDTH*Tn-1:0] sel_q, sel_d;
    logic [Tn-1:0]           lane_valid_q, lane_valid_d;
    logic                    olast_q, olast_d;

    logic                    b_exists;
    logic [CW-1:0]           b_idx;
    logic [D-1:0]            in_e;
    logic [Tn-1:0]           lane_hit;
    logic [SEL_WIDTH*Tn-1:0] lane_sel;
    logic [VW-1:0]           lane_dat;

    logic                    ready_w;
    logic                    accept;
    logic                    load;
    logic                    any_after_e;
    logic                    issue_last;
    logic [CW-1:0]           retire;
    logic [Tn-1:0]           pend_after [D];

    assign ready_w = (count_q < CW'(D));
    assign accept  = i_valid && ready_w;

    // The eligible window stops at the first barrier slot so lanes never cross a group.
    always_comb begin
        b_exists = 1'b0;
        b_idx    = '0;
        in_e     = '0;
        for (int s = D - 1; s >= 0; s--) begin
            if (CW'(s) < count_q && last_q[s]) begin
                b_exists = 1'b1;
                b_idx    = CW'(s);
            end
        end
        for (int s = 0; s < D; s++) begin
            in_e[s] = (CW'(s) < count_q) && (!b_exists || CW'(s) <= b_idx);
        end
    end

    for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
        logic                 hit;
        logic [SEL_WIDTH-1:0] sel;
        logic [BIT_WIDTH-1:0] dat;

        // Scan from the youngest slot down so the oldest pending slot wins.
        always_comb begin
            hit = 1'b0;
            sel = '0;
            dat = '0;
            for (int s = D - 1; s >= 0; s--) begin
                if (in_e[s] && pend_q[s][gi]) begin
                    hit = 1'b1;
                    sel = SEL_WIDTH'(s);
                    dat = data_q[s][gi*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end

        assign lane_hit[gi]                          = hit;
        assign lane_sel[gi*SEL_WIDTH +: SEL_WIDTH]   = sel;
        assign lane_dat[gi*BIT_WIDTH +: BIT_WIDTH]   = dat;
    end

    always_comb begin
        load = (!valid_q || i_ready) && (count_q != '0) && ((|lane_hit) || b_exists);

        any_after_e = 1'b0;
        for (int s = 0; s < D; s++) begin
            pend_after[s] = pend_q[s];
            for (int l = 0; l < Tn; l++) begin
                if (load && lane_hit[l] && lane_sel[l*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(s)) begin
                    pend_after[s][l] = 1'b0;
                end
            end
            if (in_e[s] && (|pend_after[s])) begin
                any_after_e = 1'b1;
            end
        end

        issue_last = load && b_exists && !any_after_e;

        // A closed group retires whole; otherwise only a drained, non-barrier head leaves.
        if (issue_last) begin
            retire = b_idx + CW'(1);
        end else if (count_q != '0 && pend_after[0] == '0 && !last_q[0]) begin
            retire = CW'(1);
        end else begin
            retire = '0;
        end

        for (int j = 0; j < D; j++) begin
            data_d[j] = '0;
            pend_d[j] = '0;
            last_d[j] = 1'b0;
            for (int k = 0; k < D; k++) begin
                if (k == j + int'(retire)) begin
                    data_d[j] = data_q[k];
                    pend_d[j] = pend_after[k];
                    last_d[j] = last_q[k];
                end
            end
            if (accept && j == int'(count_q) - int'(retire)) begin
                data_d[j] = i_inputs;
                last_d[j] = i_last;
                for (int l = 0; l < Tn; l++) begin
                    pend_d[j][l] = (i_inputs[l*BIT_WIDTH +: BIT_WIDTH] != '0);
                end
            end
        end

        count_d = count_q + CW'(accept) - retire;

        valid_d      = valid_q;
        outputs_d    = outputs_q;
        sel_d        = sel_q;
        lane_valid_d = lane_valid_q;
        olast_d      = olast_q;
        if (load) begin
            valid_d      = 1'b1;
            outputs_d    = lane_dat;
            sel_d        = lane_sel;
            lane_valid_d = lane_hit;
            olast_d      = issue_last;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < D; s++) begin
                data_q[s] <= '0;
                pend_q[s] <= '0;
            end
            last_q       <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            outputs_q    <= '0;
            sel_q        <= '0;
            lane_valid_q <= '0;
            olast_q      <= 1'b0;
        end else begin
            for (int s = 0; s < D; s++) begin
                data_q[s] <= data_d[s];
                pend_q[s] <= pend_d[s];
            end
            last_q       <= last_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            outputs_q    <= outputs_d;
            sel_q        <= sel_d;
            lane_valid_q <= lane_valid_d;
            olast_q      <= olast_d;
        end
    end

    assign o_ready      = ready_w;
    assign o_valid      = valid_q;
    assign o_outputs    = outputs_q;
    assign o_sel_lines  = sel_q;
    assign o_lane_valid = lane_valid_q;
    assign o_last       = olast_q;

endmodule

// File: tb/tb_nbin_zero_skip_window.sv
// Directed bench for nbin_zero_skip_window: reset, passthrough, promotion, blank groups,
// backpressure and barriers, with hand-computed expected outputs.
module tb_nbin_zero_skip_window;
    localparam int BW = 16;
    localparam int TN = 16;
    localparam int DD = 4;
    localparam int SW = 2;
    localparam int VW = BW * TN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [VW-1:0] i_inputs;
    logic          i_last;
    logic          o_valid;
    logic          i_ready;
    logic [VW-1:0] o_outputs;
    logic [SW*TN-1:0] o_sel_lines;
    logic [TN-1:0] o_lane_valid;
    logic          o_last;

    int checks = 0;
    int errors = 0;

    nbin_zero_skip_window #(
        .BIT_WIDTH(BW), .Tn(TN), .D(DD), .SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_inputs(i_inputs), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_outputs(o_outputs),
        .o_sel_lines(o_sel_lines), .o_lane_valid(o_lane_valid), .o_last(o_last)
    );

    always #5 clk = ~clk;

    // Output transfers observed on the falling edge before the consuming rising edge.
    logic [VW-1:0]    q_dat [$];
    logic [TN-1:0]    q_lv [$];
    logic [SW*TN-1:0] q_sel [$];
    logic             q_last [$];

    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            q_dat.push_back(o_outputs);
            q_lv.push_back(o_lane_valid);
            q_sel.push_back(o_sel_lines);
            q_last.push_back(o_last);
            $display("  out: data=%h lv=%h sel=%h last=%b", o_outputs, o_lane_valid, o_sel_lines, o_last);
        end
    end

    function automatic logic [VW-1:0] mk(input int base, input int zlane, input logic [BW-1:0] zval);
        logic [VW-1:0] v;
        for (int l = 0; l < TN; l++) begin
            v[l*BW +: BW] = (l == zlane) ? zval : BW'(base + l);
        end
        return v;
    endfunction

    task automatic clear_q();
        q_dat.delete(); q_lv.delete(); q_sel.delete(); q_last.delete();
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] v, input logic last);
        bit acc;
        bit done;
        i_inputs = v;
        i_last   = last;
        i_valid  = 1'b1;
        done     = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: accepted=%0b required=1", done);
        end
        $display("  in : data=%h last=%b", v, last);
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] v;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b valid=%b required ready=1 valid=0", o_ready, o_valid);
        end
        i_ready = 1'b0;
        send(mk(16'h0010, -1, '0), 1'b0);
        send(mk(16'h0030, -1, '0), 1'b0);
        send(mk(16'h0050, -1, '0), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (o_valid !== 1'b0 || o_outputs !== '0 || o_sel_lines !== '0 || o_lane_valid !== '0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b out=%h sel=%h lv=%h last=%b required all 0",
                     o_valid, o_outputs, o_sel_lines, o_lane_valid, o_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b required 1", o_ready);
        end
        clear_q();
        i_ready = 1'b1;
        v = mk(16'h0700, -1, '0);
        send(v, 1'b1);
        idle(8);
        checks++;
        if (q_dat.size() != 1) begin
            errors++;
            $display("FAIL reset_next_count: outputs=%0d required 1", q_dat.size());
        end else begin
            checks++;
            if (q_dat[0] !== v || q_last[0] !== 1'b1 || q_lv[0] !== 16'hFFFF) begin
                errors++;
                $display("FAIL reset_next_vec: data=%h last=%b lv=%h required data=%h last=1 lv=ffff",
                         q_dat[0], q_last[0], q_lv[0], v);
            end
        end
    endtask

    task automatic test_dense();
        logic [VW-1:0] v [4];
        clear_q();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) v[i] = mk(1 + i * 256, -1, '0);
        for (int i = 0; i < 4; i++) begin
            i_inputs = v[i];
            i_last   = (i == 3);
            i_valid  = 1'b1;
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL dense_ready%0d: ready=%b required 1", i, o_ready);
            end
            @(posedge clk); #1;
            $display("  in : data=%h last=%b", v[i], (i == 3));
            if (i < 2) begin
                checks++;
                if (o_valid !== (i == 1)) begin
                    errors++;
                    $display("FAIL dense_latency%0d: valid=%b required %b", i, o_valid, (i == 1));
                end
            end
        end
        idle(8);
        checks++;
        if (q_dat.size() != 4) begin
            errors++;
            $display("FAIL dense_count: outputs=%0d required 4", q_dat.size());
        end
        for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
            checks++;
            if (q_dat[i] !== v[i] || q_sel[i] !== '0 || q_lv[i] !== 16'hFFFF || q_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL dense_out%0d: data=%h sel=%h lv=%h last=%b required data=%h sel=0 lv=ffff last=%b",
                         i, q_dat[i], q_sel[i], q_lv[i], q_last[i], v[i], (i == 3));
            end
        end
    endtask

    task automatic test_promotion();
        logic [VW-1:0]    dummy, v0, v1;
        logic [VW-1:0]    e_dat [3];
        logic [TN-1:0]    e_lv [3];
        logic [SW*TN-1:0] e_sel [3];
        logic             e_last [3];
        clear_q();
        dummy = mk(16'h0A00, -1, '0);
        v0    = mk(16'h0200, 3, '0);
        v1    = mk(16'h0300, 3, 16'h0055);
        i_ready = 1'b0;
        send(dummy, 1'b1);
        send(v0, 1'b0);
        send(v1, 1'b1);
        idle(2);
        checks++;
        if (o_valid !== 1'b1 || o_outputs !== dummy) begin
            errors++;
            $display("FAIL promo_hold: valid=%b out=%h required valid=1 out=%h", o_valid, o_outputs, dummy);
        end
        i_ready = 1'b1;
        idle(8);
        e_dat[0] = dummy;                    e_lv[0] = 16'hFFFF; e_sel[0] = '0;           e_last[0] = 1'b1;
        e_dat[1] = mk(16'h0200, 3, 16'h0055); e_lv[1] = 16'hFFFF; e_sel[1] = 32'h0000_0040; e_last[1] = 1'b0;
        e_dat[2] = mk(16'h0300, 3, '0);      e_lv[2] = 16'hFFF7; e_sel[2] = '0;           e_last[2] = 1'b1;
        checks++;
        if (q_dat.size() != 3) begin
            errors++;
            $display("FAIL promo_count: outputs=%0d required 3", q_dat.size());
        end
        for (int i = 0; i < 3 && i < q_dat.size(); i++) begin
            checks++;
            if (q_dat[i] !== e_dat[i] || q_lv[i] !== e_lv[i] || q_sel[i] !== e_sel[i] || q_last[i] !== e_last[i]) begin
                errors++;
                $display("FAIL promo_out%0d: data=%h lv=%h sel=%h last=%b required data=%h lv=%h sel=%h last=%b",
                         i, q_dat[i], q_lv[i], q_sel[i], q_last[i], e_dat[i], e_lv[i], e_sel[i], e_last[i]);
            end
        end
    endtask

    task automatic test_all_zero();
        clear_q();
        i_ready = 1'b1;
        send('0, 1'b0);
        send('0, 1'b1);
        idle(8);
        checks++;
        if (q_dat.size() != 1) begin
            errors++;
            $display("FAIL zero_count: outputs=%0d required 1", q_dat.size());
        end else begin
            checks++;
            if (q_dat[0] !== '0 || q_lv[0] !== '0 || q_sel[0] !== '0 || q_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL zero_out: data=%h lv=%h sel=%h last=%b required 0 0 0 1",
                         q_dat[0], q_lv[0], q_sel[0], q_last[0]);
            end
        end
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_empty: ready=%b valid=%b required ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_back_to_back_full();
        logic [VW-1:0] v [6];
        clear_q();
        for (int i = 0; i < 6; i++) v[i] = mk(16'h1000 + i * 256, -1, '0);
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(v[i], 1'b0);
            if (i >= 1) begin
                checks++;
                if (o_valid !== 1'b1 || o_outputs !== v[0]) begin
                    errors++;
                    $display("FAIL full_stable%0d: valid=%b out=%h required valid=1 out=%h", i, o_valid, o_outputs, v[0]);
                end
            end
        end
        i_inputs = v[5];
        i_last   = 1'b1;
        i_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_ready !== 1'b0 || o_outputs !== v[0]) begin
                errors++;
                $display("FAIL full_blocked%0d: ready=%b out=%h required ready=0 out=%h", c, o_ready, o_outputs, v[0]);
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        send(v[5], 1'b1);
        idle(12);
        checks++;
        if (q_dat.size() != 6) begin
            errors++;
            $display("FAIL full_count: outputs=%0d required 6", q_dat.size());
        end
        for (int i = 0; i < 6 && i < q_dat.size(); i++) begin
            checks++;
            if (q_dat[i] !== v[i] || q_lv[i] !== 16'hFFFF || q_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL full_out%0d: data=%h lv=%h last=%b required data=%h lv=ffff last=%b",
                         i, q_dat[i], q_lv[i], q_last[i], v[i], (i == 5));
            end
        end
    endtask

    task automatic test_barrier();
        logic [VW-1:0] v0, v1;
        clear_q();
        v0 = mk(16'h0400, 0, '0);
        v1 = mk(16'h0500, 0, 16'h0777);
        i_ready = 1'b1;
        send(v0, 1'b1);
        send(v1, 1'b1);
        idle(8);
        checks++;
        if (q_dat.size() != 2) begin
            errors++;
            $display("FAIL barrier_count: outputs=%0d required 2", q_dat.size());
        end else begin
            checks++;
            if (q_dat[0] !== v0 || q_lv[0] !== 16'hFFFE || q_sel[0] !== '0 || q_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL barrier_out0: data=%h lv=%h sel=%h last=%b required data=%h lv=fffe sel=0 last=1",
                         q_dat[0], q_lv[0], q_sel[0], q_last[0], v0);
            end
            checks++;
            if (q_dat[1] !== v1 || q_lv[1] !== 16'hFFFF || q_sel[1] !== '0 || q_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL barrier_out1: data=%h lv=%h sel=%h last=%b required data=%h lv=ffff sel=0 last=1",
                         q_dat[1], q_lv[1], q_sel[1], q_last[1], v1);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_inputs = '0;
        i_last   = 1'b0;
        i_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_dense();
        test_promotion();
        test_all_zero();
        test_back_to_back_full();
        test_barrier();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1, "timeout");
    end

endmodule
